// File: rtl/dram_stream_feeder_pkg.sv
// Shared FSM encoding, snake-order address helper and output width for the DRAM stream feeder.
// FEEDER_REPLICATE_EN widens the pixel output to `CHANNEL_OUT byte lanes.
`ifndef CHANNEL_OUT
`define CHANNEL_OUT 4
`endif

package feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

`ifdef FEEDER_REPLICATE_EN
  localparam int FEED_OUT_W = `CHANNEL_OUT * 8;
`else
  localparam int FEED_OUT_W = 8;
`endif

  // Counter width that stays legal for a range of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int snake_addr(input int ch, input int row, input int col,
                                    input int rows, input int cols);
    return ch * rows * cols + row * cols + col;
  endfunction

endpackage

// File: rtl/dram_stream_feeder_if.sv
// Memory-read and pixel-stream signals of the DRAM stream feeder.
// Compiled with the package, so FEEDER_REPLICATE_EN also sets the default dout width here.
interface dram_stream_feeder_if #(
  parameter int ADDR_W = 14,
  parameter int OUT_W  = feeder_pkg::FEED_OUT_W
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [7:0]        mem_rdata;
  logic [OUT_W-1:0]  dout;
  logic              dout_valid;
  logic              dout_ready;

  // mem_req/mem_addr is fire-and-forget (one address per cycle); mem_rvalid returns data in
  // order. dout transfers when dout_valid & dout_ready; while valid and not ready, dout holds.
  modport master (
    output mem_req, mem_addr, dout, dout_valid,
    input  mem_rvalid, mem_rdata, dout_ready
  );

  modport slave (
    input  mem_req, mem_addr, dout, dout_valid,
    output mem_rvalid, mem_rdata, dout_ready
  );
endinterface

// File: rtl/dram_stream_feeder_fifo.sv
// Byte FIFO buffering read returns for the feeder; output comes from storage registers,
// so a pushed byte is visible no earlier than the next cycle.
module feeder_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   count_q;
  logic          do_pop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PW+1)'(DEPTH));
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop) rd_q <= rd_q + PW'(1);
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(do_pop);
    end
  end

  // Empty reads as zero so stale bytes never sit on the bus.
  assign dout  = empty ? 8'h00 : mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/dram_stream_feeder.sv
// Streams CH_NUM channels of a ROW x COL feature map from DRAM in snake order into a pixel stream.
// FEEDER_REPLICATE_EN: dout carries the byte replicated across `CHANNEL_OUT lanes.
module dram_stream_feeder
  import feeder_pkg::*;
#(
  parameter int ROW        = 256,
  parameter int COL        = 16,
  parameter int CH_NUM     = 3,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output feeder_state_e         state_o,
  dram_stream_feeder_if.master  bus
);
  localparam int ROW_W = cnt_w(ROW);
  localparam int COL_W = cnt_w(COL);
  localparam int CH_W  = cnt_w(CH_NUM);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e     state_q;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              mem_req_q, last_q, busy_q, done_q;
  logic [ADDR_W-1:0] mem_addr_q, addr;

  logic [CNT_W-1:0]  fifo_count, count_d;
  logic              fifo_empty, fifo_full;
  logic [7:0]        fifo_dout;
  logic              push, pop, fetch_next, credit_ok, issue, is_last, at_row_end;

  // Returns arriving with nothing in flight (e.g. after a reset) are discarded.
  assign pop  = !fifo_empty && bus.dout_ready;
  assign push = bus.mem_rvalid && (inflight_q != '0) && (!fifo_full || pop);

  feeder_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.mem_rdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign addr       = ADDR_W'(snake_addr(int'(ch_q), int'(row_q), int'(col_q), ROW, COL));
  assign at_row_end = row_q[0] ? (col_q == '0) : (col_q == COL_W'(COL - 1));
  assign is_last    = at_row_end && (row_q == ROW_W'(ROW - 1)) && (ch_q == CH_W'(CH_NUM - 1));

  // Next-cycle occupancy decides whether a request may be registered for the next cycle.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(mem_req_q) - CNT_W'(push);
    count_d    = fifo_count + CNT_W'(push) - CNT_W'(pop);
    credit_ok  = ({1'b0, count_d} + {1'b0, inflight_d}) < (CNT_W+1)'(FIFO_DEPTH);
    fetch_next = ((state_q == ST_IDLE) && start) ||
                 ((state_q == ST_FETCH) && !(mem_req_q && last_q));
    issue      = fetch_next && credit_ok;
  end

  // Snake walk: the row turn keeps the column index, so no bubble between rows.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    ch_d  = ch_q;
    if (!at_row_end) begin
      col_d = row_q[0] ? (col_q - COL_W'(1)) : (col_q + COL_W'(1));
    end else if (row_q != ROW_W'(ROW - 1)) begin
      row_d = row_q + ROW_W'(1);
    end else begin
      row_d = '0;
      col_d = '0;
      ch_d  = ch_q + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      ch_q       <= '0;
      inflight_q <= '0;
      mem_req_q  <= 1'b0;
      last_q     <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      mem_req_q  <= issue;
      last_q     <= issue && is_last;
      mem_addr_q <= issue ? addr : '0;
      done_q     <= 1'b0;
      if (issue) begin
        row_q <= row_d;
        col_q <= col_d;
        ch_q  <= ch_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (mem_req_q && last_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((count_d == '0) && (inflight_d == '0)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          row_q   <= '0;
          col_q   <= '0;
          ch_q    <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.dout_valid = !fifo_empty;
`ifdef FEEDER_REPLICATE_EN
  assign bus.dout       = {`CHANNEL_OUT{fifo_dout}};
`else
  assign bus.dout       = fifo_dout;
`endif
  assign busy           = busy_q;
  assign done           = done_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_dram_stream_feeder.sv
// Self-checking bench for dram_stream_feeder: in-order random-latency memory model, snake-order
// reference queues, fixed address table, stall / restart / mid-stream reset sequences.
module tb_dram_stream_feeder;
  import feeder_pkg::*;

  localparam int ROW    = 16;
  localparam int COL    = 4;
  localparam int CH_NUM = 3;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int NPIX   = ROW * COL * CH_NUM;
  localparam int OUT_W  = FEED_OUT_W;
  localparam int BUDGET = 4000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  feeder_state_e state;

  dram_stream_feeder_if #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  dram_stream_feeder #(
    .ROW(ROW), .COL(COL), .CH_NUM(CH_NUM), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .state_o (state),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model state / scoreboard ----------------
  typedef struct { int addr; int due; } rsp_t;
  typedef struct { int req_idx; int exp_addr; } vec_t;

  logic [7:0]        mem_data [2**ADDR_W];
  rsp_t              rsp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [OUT_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] got_addr [NPIX];
  logic [OUT_W-1:0]  first_dout;
  logic [OUT_W-1:0]  exp_a5;
  vec_t              tbl [15];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_due = 0;
  bit ab;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [OUT_W-1:0] rep(input logic [7:0] b);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int l = 0; l < OUT_W / 8; l++) r[l*8 +: 8] = b;
    return r;
  endfunction

  // Reference stream: channels, then rows, each row walked left-to-right or right-to-left.
  task automatic build_model();
    int col, a;
    exp_addr_q.delete();
    exp_q.delete();
    for (int ch = 0; ch < CH_NUM; ch++)
      for (int row = 0; row < ROW; row++)
        for (int k = 0; k < COL; k++) begin
          col = (row % 2 == 1) ? (COL - 1 - k) : k;
          a   = ch * ROW * COL + row * COL + col;
          exp_addr_q.push_back(ADDR_W'(a));
          exp_q.push_back(rep(mem_data[a]));
        end
  endtask

  // ---------------- driver tasks ----------------
  task automatic mem_step(input int lat_min, input int lat_max);
    rsp_t r;
    if (bus.mem_req) begin
      r.addr = int'(bus.mem_addr);
      r.due  = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      rsp_q.push_back(r);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_data[rsp_q[0].addr];
      void'(rsp_q.pop_front());
    end
  endtask

  task automatic run_stream(input string tag, input int lat_min, input int lat_max,
                            input int ready_pct, input int stall_at, input int restart_every,
                            input int rst_at, output bit aborted);
    int issued = 0;
    int popped = 0;
    int done_cnt = 0;
    int done_cyc = -100;
    int last_hs = -100;
    int stall_left = 20;
    int t0;
    bit hold = 1'b0;
    bit rdy;
    logic [OUT_W-1:0] held = '0;
    aborted = 1'b0;
    build_model();
    bus.mem_rvalid = 1'b0;
    bus.dout_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    t0 = cyc;
    forever begin
      if (bus.mem_req) begin
        check({tag, "_credit"}, (issued - popped) < DEPTH, 1);
        if (exp_addr_q.size() == 0) fail_now({tag, "_extra_req"});
        else check({tag, "_req_addr"}, bus.mem_addr, exp_addr_q.pop_front());
        if (issued < NPIX) got_addr[issued] = bus.mem_addr;
        issued++;
      end
      if (hold) begin
        check({tag, "_hold_valid"}, bus.dout_valid, 1);
        check({tag, "_hold_data"}, bus.dout, held);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({tag, "_done_after_last_hs"}, cyc, last_hs + 1);
      end
      mem_step(lat_min, lat_max);
      rdy = (int'($urandom_range(99, 0)) < ready_pct);
      if (stall_at >= 0 && popped >= stall_at && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      bus.dout_ready = rdy;
      if (bus.dout_valid && rdy) begin
        if (exp_q.size() == 0) fail_now({tag, "_extra_pixel"});
        else check({tag, "_pixel"}, bus.dout, exp_q.pop_front());
        if (popped == 0) first_dout = bus.dout;
        popped++;
        last_hs = cyc;
      end
      hold  = bus.dout_valid && !rdy;
      held  = bus.dout;
      start = (restart_every > 0) && busy && (cyc % restart_every == 0);
      if (rst_at >= 0 && popped >= rst_at && rsp_q.size() >= 3) begin
        aborted = 1'b1;
        start   = 1'b0;
        rst_n   = 1'b0;
        break;
      end
      if (popped == NPIX && done_cnt > 0 && cyc >= done_cyc + 2) break;
      if (cyc - t0 > BUDGET) begin
        fail_now({tag, "_timeout"});
        break;
      end
      tick();
    end
    start = 1'b0;
    if (!aborted) begin
      check({tag, "_issued"}, issued, NPIX);
      check({tag, "_popped"}, popped, NPIX);
      check({tag, "_single_done"}, done_cnt, 1);
      check({tag, "_busy_end"}, busy, 0);
      check({tag, "_state_end"}, state, ST_IDLE);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 8'h00;
    bus.dout_ready = 1'b0;
    for (int a = 0; a < 2**ADDR_W; a++) mem_data[a] = 8'($urandom);
    mem_data[0] = 8'hA5;
`ifdef FEEDER_REPLICATE_EN
    exp_a5 = {`CHANNEL_OUT{8'hA5}};
`else
    exp_a5 = 8'hA5;
`endif
    tbl = '{'{0, 0}, '{1, 1}, '{3, 3}, '{4, 7}, '{5, 6}, '{7, 4}, '{8, 8}, '{12, 15},
            '{60, 63}, '{63, 60}, '{64, 64}, '{68, 71}, '{127, 124}, '{128, 128},
            '{191, 188}};

    tick();
    tick();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state, ST_IDLE);
    rst_n = 1'b1;
    tick();
    check("post_rst_mem_req", bus.mem_req, 0);
    check("post_rst_busy", busy, 0);

    run_stream("lat1", 1, 1, 100, -1, 0, -1, ab);
    for (int i = 0; i < 15; i++)
      check($sformatf("tbl_addr_%0d", tbl[i].req_idx), got_addr[tbl[i].req_idx],
            tbl[i].exp_addr);
    check("rep_a5", first_dout, exp_a5);

    run_stream("lat5", 5, 5, 100, -1, 0, -1, ab);
    run_stream("rand", 1, 8, 70, -1, 0, -1, ab);
    run_stream("stall", 3, 6, 100, 30, 0, -1, ab);
    run_stream("restart", 1, 4, 80, -1, 7, -1, ab);

    // Mid-stream reset with reads still outstanding, then late returns must vanish.
    run_stream("reset_mid", 5, 5, 100, -1, 0, 40, ab);
    check("reset_triggered", ab, 1);
    tick();
    rst_n = 1'b1;
    check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_dout", bus.dout, 0);
    check("mid_rst_dout_valid", bus.dout_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", state, ST_IDLE);
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 40 && (rsp_q.size() > 0 || i < 4); i++) begin
      check("late_rvalid_dropped", bus.dout_valid, 0);
      check("idle_no_req", bus.mem_req, 0);
      mem_step(5, 5);
      tick();
    end
    if (rsp_q.size() > 0) fail_now("late_rvalid_drain_timeout");
    check("post_drain_valid", bus.dout_valid, 0);
    bus.mem_rvalid = 1'b0;
    tick();

    run_stream("after_reset", 5, 5, 100, -1, 0, -1, ab);
    check("restart_addr0", got_addr[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dram_stream_feeder.md
DRAM_STREAM_FEEDER -- requirements
Module: dram_stream_feeder

Interface
REQ-001 SHALL have parameter ROW, default 256, feature-map rows per channel.
REQ-002 SHALL have parameter COL, default 16, feature-map columns per row.
REQ-003 SHALL have parameter CH_NUM, default 3, input channels streamed back to back.
REQ-004 SHALL have parameter ADDR_W, default 14, external read-address width; must satisfy 2^ADDR_W >= CH_NUM*ROW*COL.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries, power of two.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 start  in  1  one-cycle pulse that begins a full CH_NUM-channel stream.
REQ-009 mem_req  out  1  read request, one address per asserted cycle.
REQ-010 mem_addr  out  ADDR_W  read address, valid when mem_req=1.
REQ-011 mem_rvalid  in  1  read-data strobe; responses return in order, latency >= 1 cycle, unbounded.
REQ-012 mem_rdata  in  8  read byte, valid when mem_rvalid=1.
REQ-013 dout  out  OUT_W  pixel to sram_controller data_in_1; OUT_W per REQ-033.
REQ-014 dout_valid  out  1  dout holds a pixel.
REQ-015 dout_ready  in  1  consumer accepts dout this cycle.
REQ-016 busy  out  1  high from the cycle after accepted start until done.
REQ-017 done  out  1  one-cycle pulse after the last pixel handshake.

Function
REQ-018 SHALL have FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after last request issued; DRAIN->DONE when FIFO empty and in-flight count is 0; DONE->IDLE unconditionally after 1 cycle, done=1 while in DONE.
REQ-019 SHALL order reads in snake order per channel: even rows col 0..COL-1 ascending, odd rows col COL-1..0 descending, rows 0..ROW-1, then channels 0..CH_NUM-1.
REQ-020 SHALL compute mem_addr = ch*ROW*COL + row*COL + col, zero-extended to ADDR_W.
REQ-021 SHALL assert mem_req only in FETCH when fifo_count + inflight < FIFO_DEPTH (credit rule), so buffer overflow is impossible.
REQ-022 SHALL increment inflight on mem_req, decrement on mem_rvalid; simultaneous events leave it unchanged.
REQ-023 SHALL push mem_rdata into the FIFO on mem_rvalid when inflight > 0; SHALL drop mem_rvalid when inflight = 0.
REQ-024 SHALL drive dout_valid = FIFO not empty; pop on dout_valid & dout_ready; push and pop in the same cycle SHALL keep count unchanged.
REQ-025 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-026 SHALL permit a pixel to reach dout no earlier than the cycle after its mem_rvalid (registered FIFO output).
REQ-027 SHALL ignore start in any state other than IDLE.
REQ-028 SHALL wrap col at each row end without a bubble cycle: last col of row r followed next request by first col of row r+1, same col index (snake turn).

Reset
REQ-029 SHALL, on rst_n=0 at a clock edge, set state IDLE, counters row/col/ch/inflight/fifo_count to 0.
REQ-030 SHALL hold mem_req=0, mem_addr=0, dout=0, dout_valid=0, busy=0, done=0 during and after reset.
REQ-031 SHALL, on reset mid-stream, abandon the stream; late mem_rvalid after reset SHALL be dropped per REQ-023.

Configuration
REQ-032 SHALL honour macro FEEDER_REPLICATE_EN.
REQ-033 SHALL, with FEEDER_REPLICATE_EN defined, set OUT_W = `CHANNEL_OUT*8 with the byte replicated in every lane; without it, OUT_W = 8 and dout is the raw byte.

Structure
REQ-034 SHALL take FSM state encoding and the snake-address function from the shared package feeder_pkg; `CHANNEL_OUT from the existing global define file.
REQ-035 SHALL implement the buffer as sub-module feeder_fifo (parameter DEPTH, 8-bit data, push/pop/count/empty/full).

Verification
REQ-036 ROW=2, COL=4, CH_NUM=1, 1-cycle memory, dout_ready=1 -> mem_addr sequence 0,1,2,3,7,6,5,4; done one cycle after 8th handshake.
REQ-037 Default params, memory latency 5 cycles -> mem_req never high when fifo_count+inflight=4; all 12288 pixels match snake-ordered file data.
REQ-038 dout_ready held 0 for 20 cycles mid-stream -> dout constant, no more than 4 outstanding reads, no data loss after release.
REQ-039 start pulsed again while busy=1 -> ignored, address sequence unchanged, single done.
REQ-040 rst_n low for 1 cycle at pixel 100 with 3 reads in flight -> outputs at reset values, late rvalids dropped, fresh start restarts from addr 0.
REQ-041 FEEDER_REPLICATE_EN defined, `CHANNEL_OUT=4, byte 0xA5 -> dout = 0xA5A5A5A5; undefined -> dout = 0xA5.
